s_wr_sched: RTL and testbench
=============================

Name: s_wr_sched

Overview:
- Write-port scheduler and reservation scoreboard for the 8-entry scalar (S) register file.
- Functional units return S results through it. It round-robin arbitrates them onto the register file's single write port (i_wr_en/i_wr_addr/i_wr_data).
- It tracks one reservation bit per S register. Instruction issue stalls on read-after-write and write-after-write hazards against in-flight results.

Parameters:
NREQ, 4, number of functional-unit result requesters (>=2)
WIDTH, 64, scalar data width
LOGDEPTH, 3, S register address width (DEPTH = 2**LOGDEPTH)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  reset
i_flush  in  1  synchronous flush (exchange/abort)
i_iss_valid  in  1  instruction presented for issue
i_iss_dest  in  LOGDEPTH  destination S register to reserve
i_iss_j_addr  in  LOGDEPTH  j operand S register
i_iss_k_addr  in  LOGDEPTH  k operand S register
i_iss_uses_j  in  1  j operand is read
i_iss_uses_k  in  1  k operand is read
o_iss_stall  out  1  issue blocked this cycle (combinational)
i_fu_valid  in  NREQ  result valid per requester; held until acked
i_fu_addr  in  NREQ*LOGDEPTH  packed destination addresses, requester r at [r*LOGDEPTH +: LOGDEPTH]
i_fu_data  in  NREQ*WIDTH  packed result data, requester r at [r*WIDTH +: WIDTH]
o_fu_ack  out  NREQ  one-hot grant (combinational); the result is consumed at this edge
o_wr_en  out  1  register file write enable (registered)
o_wr_addr  out  LOGDEPTH  register file write address (registered)
o_wr_data  out  WIDTH  register file write data (registered)
o_busy  out  1  OR of all reservation bits
o_err  out  1  sticky: a write was committed to an unreserved register

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. rst_n low clears all state immediately, regardless of any in-flight operation:
  - res[] = 0, ptr = 0
  - o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0
  - o_err = 0, o_busy = 0
- Reservations:
  - Define clr_vec = one-hot(o_wr_addr) when o_wr_en = 1, else 0.
  - eff = res & ~clr_vec. A register being written this cycle counts as free, because the register file forwards the write data to its read ports.
- Stall:
  - o_iss_stall = i_iss_valid & (eff[dest] | (uses_j & j_addr!=0 & eff[j]) | (uses_k & k_addr!=0 & eff[k])).
  - Address 0 as a j/k operand is a constant (j reads 0, k reads 2^63), so it never creates a read hazard. dest 0 is still checked.
  - o_iss_stall = 0 whenever i_iss_valid = 0.
- Issue accept: when i_iss_valid & ~o_iss_stall & ~i_flush, set res[dest] at the edge.
- Bit update at each edge: res <= (res & ~clr_vec) | set_vec. If the same register is both cleared and set in one cycle, the set wins.
- Arbitration:
  - Grant the first requester r with i_fu_valid[r] = 1, searching ptr, ptr+1, … modulo NREQ.
  - o_fu_ack[r] = 1 in the same cycle, combinationally. At most one ack per cycle.
  - At the edge: o_wr_en <= 1, and o_wr_addr/o_wr_data <= the granted requester's fields. Latency from valid to write = 1 cycle; sustained throughput = 1 write per cycle.
  - After a grant, ptr <= (r+1) mod NREQ. With no grant, ptr is held and o_wr_en <= 0.
- Error: when a grant is made to an address whose effective bit is 0, o_err <= 1. The write still proceeds. o_err is cleared only by reset.
- Flush: i_flush = 1 for one cycle has these effects at the edge:
  - res <= 0 and ptr <= 0.
  - o_wr_en <= 0, so no new write is launched.
  - o_fu_ack = 0 in the flush cycle.
  - A write already on o_wr_en during the flush cycle still commits.
  - Issue is ignored.
  - o_err is unchanged.
- o_busy = |res, taken from the registered res.

Test Plan:
- Reset/idle: assert rst_n = 0 mid-stream with o_wr_en = 1 and res = 8'h0F -> all outputs 0 immediately; after release with no requests, o_wr_en stays 0 and o_busy = 0.
- RAW stall and bypass release: issue dest = 3; next cycle issue j = 3 with uses_j -> o_iss_stall = 1. FU1 returns addr 3, data 64'hDEAD_BEEF -> ack in cycle N, o_wr_en/addr 3/data 64'hDEAD_BEEF in cycle N+1, stall drops in cycle N+1, res[3] = 0 after that edge.
- Round-robin fairness: hold i_fu_valid = 4'b1111 from ptr = 0 -> acks 0001, 0010, 0100, 1000, 0001 on consecutive cycles; o_wr_en high on each following cycle.
- Constant operands and same-cycle set/clear: with res[0] = 1, issue j = 0, k = 0, dest = 5 -> no stall. In the cycle o_wr_en commits addr 5, issue dest = 5 -> no stall, and res[5] = 1 after the edge.
- Error and flush: FU2 writes addr 6 with res[6] = 0 -> o_err = 1 and stays high. Then with res = 8'hF0 and i_fu_valid = 4'b0001, pulse i_flush -> ack = 0, res = 0, o_busy = 0 next cycle, o_wr_en = 0.

Source files
------------

// File: rtl/s_wr_sched.sv
// s_wr_sched: write-port scheduler and reservation scoreboard for the scalar register file.
//   Functional units return results here. A round-robin arbiter picks one per cycle and drives
//   the registered register-file write port. A per-register reservation bit blocks issue on
//   RAW/WAW hazards against results that are still in flight.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_flush                    synchronous flush: drops reservations, arbiter state, new writes
//   i_iss_*                    instruction issue request (dest, j/k operands and their use flags)
//   o_iss_stall                combinational issue stall
//   i_fu_valid/addr/data       packed per-requester result returns
//   o_fu_ack                   one-hot combinational grant (result consumed at the edge)
//   o_wr_en/addr/data          registered register-file write port
//   o_busy                     any register reserved
//   o_err                      sticky: a write was committed to an unreserved register
module s_wr_sched #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned LOGDEPTH = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_iss_valid,
   input  logic [LOGDEPTH-1:0]      i_iss_dest,
   input  logic [LOGDEPTH-1:0]      i_iss_j_addr,
   input  logic [LOGDEPTH-1:0]      i_iss_k_addr,
   input  logic                     i_iss_uses_j,
   input  logic                     i_iss_uses_k,
   output logic                     o_iss_stall,
   input  logic [NREQ-1:0]          i_fu_valid,
   input  logic [NREQ*LOGDEPTH-1:0] i_fu_addr,
   input  logic [NREQ*WIDTH-1:0]    i_fu_data,
   output logic [NREQ-1:0]          o_fu_ack,
   output logic                     o_wr_en,
   output logic [LOGDEPTH-1:0]      o_wr_addr,
   output logic [WIDTH-1:0]         o_wr_data,
   output logic                     o_busy,
   output logic                     o_err
);

   localparam int unsigned DEPTH = 1 << LOGDEPTH;
   localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [DEPTH-1:0]    r_res;
   logic [PW-1:0]       r_ptr;
   logic                r_wr_en;
   logic [LOGDEPTH-1:0] r_wr_addr;
   logic [WIDTH-1:0]    r_wr_data;
   logic                r_err;

   logic [DEPTH-1:0]    w_clr_vec;
   logic [DEPTH-1:0]    w_eff;
   logic [DEPTH-1:0]    w_set_vec;
   logic                w_stall;
   logic                w_gnt;
   logic [PW-1:0]       w_gnt_idx;
   logic [PW-1:0]       w_ptr_nxt;
   logic [LOGDEPTH-1:0] w_gnt_addr;
   logic [WIDTH-1:0]    w_gnt_data;

   // The register being written this cycle is forwarded by the register file, so it counts free.
   always_comb begin
      w_clr_vec = '0;
      if (r_wr_en) w_clr_vec[r_wr_addr] = 1'b1;
   end

   assign w_eff = r_res & ~w_clr_vec;

   // Operand address 0 is a constant source and never a read hazard; dest 0 is still checked.
   always_comb begin
      w_stall = 1'b0;
      if (i_iss_valid) begin
         w_stall = w_eff[i_iss_dest]
                 | (i_iss_uses_j && (i_iss_j_addr != '0) && w_eff[i_iss_j_addr])
                 | (i_iss_uses_k && (i_iss_k_addr != '0) && w_eff[i_iss_k_addr]);
      end
   end

   always_comb begin
      w_set_vec = '0;
      if (i_iss_valid && !w_stall && !i_flush) w_set_vec[i_iss_dest] = 1'b1;
   end

   // Round-robin search starting at r_ptr; flush suppresses any grant.
   always_comb begin
      logic [PW-1:0] v_idx;
      w_gnt     = 1'b0;
      w_gnt_idx = '0;
      v_idx     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         v_idx = PW'((32'(r_ptr) + i) % NREQ);
         if (!w_gnt && i_fu_valid[v_idx]) begin
            w_gnt     = 1'b1;
            w_gnt_idx = v_idx;
         end
      end
      if (i_flush) w_gnt = 1'b0;
   end

   always_comb begin
      w_gnt_addr = '0;
      w_gnt_data = '0;
      for (int unsigned r = 0; r < NREQ; r++) begin
         if (w_gnt_idx == PW'(r)) begin
            w_gnt_addr = i_fu_addr[r*LOGDEPTH +: LOGDEPTH];
            w_gnt_data = i_fu_data[r*WIDTH +: WIDTH];
         end
      end
   end

   assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

   always_comb begin
      o_fu_ack = '0;
      if (w_gnt) o_fu_ack[w_gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res     <= '0;
         r_ptr     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_err     <= 1'b0;
      end else if (i_flush) begin
         r_res   <= '0;
         r_ptr   <= '0;
         r_wr_en <= 1'b0;
      end else begin
         // Set after clear: a same-cycle re-reservation of the register being written wins.
         r_res <= w_eff | w_set_vec;
         if (w_gnt) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_gnt_addr;
            r_wr_data <= w_gnt_data;
            r_ptr     <= w_ptr_nxt;
            if (!w_eff[w_gnt_addr]) r_err <= 1'b1;
         end else begin
            r_wr_en <= 1'b0;
         end
      end
   end

   assign o_iss_stall = w_stall;
   assign o_wr_en     = r_wr_en;
   assign o_wr_addr   = r_wr_addr;
   assign o_wr_data   = r_wr_data;
   assign o_busy      = |r_res;
   assign o_err       = r_err;

endmodule

// File: tb/tb_s_wr_sched.sv
// Self-checking bench for s_wr_sched: directed scenarios plus randomized traffic, all checked
// against a behavioural scoreboard model of the reservation bits and round-robin arbiter.
module tb_s_wr_sched;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         iss_valid;
   logic [2:0]   iss_dest;
   logic [2:0]   iss_j;
   logic [2:0]   iss_k;
   logic         uses_j;
   logic         uses_k;
   logic         stall;
   logic [3:0]   fu_valid;
   logic [11:0]  fu_addr;
   logic [255:0] fu_data;
   logic [3:0]   ack;
   logic         wr_en;
   logic [2:0]   wr_addr;
   logic [63:0]  wr_data;
   logic         busy;
   logic         err;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   bit [7:0]  m_res;
   int        m_ptr;
   bit        m_wr_en;
   bit [2:0]  m_wr_addr;
   bit [63:0] m_wr_data;
   bit        m_err;

   s_wr_sched #(.NREQ(4), .WIDTH(64), .LOGDEPTH(3)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (flush),
      .i_iss_valid  (iss_valid),
      .i_iss_dest   (iss_dest),
      .i_iss_j_addr (iss_j),
      .i_iss_k_addr (iss_k),
      .i_iss_uses_j (uses_j),
      .i_iss_uses_k (uses_k),
      .o_iss_stall  (stall),
      .i_fu_valid   (fu_valid),
      .i_fu_addr    (fu_addr),
      .i_fu_data    (fu_data),
      .o_fu_ack     (ack),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_wr_data    (wr_data),
      .o_busy       (busy),
      .o_err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit [7:0] m_eff();
      bit [7:0] e;
      e = m_res;
      if (m_wr_en) e[m_wr_addr] = 1'b0;
      return e;
   endfunction

   function automatic bit m_stall();
      bit [7:0] e;
      e = m_eff();
      if (!iss_valid) return 1'b0;
      return e[iss_dest] | (uses_j && iss_j != 0 && e[iss_j]) | (uses_k && iss_k != 0 && e[iss_k]);
   endfunction

   function automatic int m_grant();
      if (flush) return -1;
      for (int k = 0; k < 4; k++) begin
         if (fu_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_res = '0; m_ptr = 0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0; m_err = 0;
   endfunction

   // Advance one clock, stepping the model with the inputs presented during that cycle.
   task automatic tick();
      int       g;
      bit [7:0] e;
      bit       st;
      bit [2:0] a;
      g  = m_grant();
      e  = m_eff();
      st = m_stall();
      @(posedge clk);
      if (flush) begin
         m_res = '0; m_ptr = 0; m_wr_en = 0;
      end else begin
         m_res = e;
         if (iss_valid && !st) m_res[iss_dest] = 1'b1;
         if (g >= 0) begin
            a = fu_addr[g*3 +: 3];
            if (!e[a]) m_err = 1'b1;
            m_wr_en = 1; m_wr_addr = a; m_wr_data = fu_data[g*64 +: 64];
            m_ptr = (g + 1) % 4;
         end else begin
            m_wr_en = 0;
         end
      end
      #1;
   endtask

   task automatic clr_in();
      flush = 0; iss_valid = 0; iss_dest = 0; iss_j = 0; iss_k = 0; uses_j = 0; uses_k = 0;
      fu_valid = 0; fu_addr = 0; fu_data = 0;
   endtask

   task automatic do_reset();
      clr_in();
      rst_n = 0;
      #1 model_reset();
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      clr_in();
      rst_n = 0;
      #1;
      model_reset();
      n_vec++; if ({wr_en, wr_addr, wr_data, busy, err} !== 70'd0) begin
         n_err++; $display("FAIL reset_initial: got %h expected 0", {wr_en, wr_addr, wr_data, busy, err});
      end
      @(negedge clk);
      rst_n = 1;
      tick();
      // Build res = 0F with a write pending, then reset mid-stream.
      for (int d = 0; d < 4; d++) begin
         iss_valid = 1; iss_dest = 3'(d);
         if (d == 3) begin
            fu_valid = 4'b0001; fu_addr[2:0] = 3'd7; fu_data[63:0] = 64'h1234;
         end
         tick();
      end
      clr_in();
      n_vec++; if (wr_en !== 1'b1 || busy !== 1'b1 || m_res != 8'h0F) begin
         n_err++; $display("FAIL reset_setup: got wr_en=%b busy=%b expected 1 1", wr_en, busy);
      end
      #2 rst_n = 0;
      #1;
      model_reset();
      n_vec++; if ({wr_en, wr_addr, wr_data, busy, err, ack} !== 74'd0) begin
         n_err++; $display("FAIL reset_async: got %h expected 0", {wr_en, wr_addr, wr_data, busy, err});
      end
      @(negedge clk);
      rst_n = 1;
      tick();
      tick();
      @(negedge clk);
      n_vec++; if (wr_en !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL reset_idle: got wr_en=%b busy=%b expected 0 0", wr_en, busy);
      end
      tick();
   endtask

   task automatic test_raw();
      iss_valid = 1; iss_dest = 3;
      @(negedge clk);
      n_vec++; if (stall !== 1'b0) begin
         n_err++; $display("FAIL raw_first_issue: got stall=%b expected 0", stall);
      end
      tick();
      iss_dest = 4; iss_j = 3; uses_j = 1;
      @(negedge clk);
      n_vec++; if (stall !== 1'b1) begin
         n_err++; $display("FAIL raw_stall: got stall=%b expected 1", stall);
      end
      tick();
      fu_valid = 4'b0010; fu_addr[5:3] = 3'd3; fu_data[127:64] = 64'hDEAD_BEEF;
      @(negedge clk);
      n_vec++; if (ack !== 4'b0010 || stall !== 1'b1) begin
         n_err++; $display("FAIL raw_ack: got ack=%b stall=%b expected 0010 1", ack, stall);
      end
      tick();
      fu_valid = 0;
      @(negedge clk);
      n_vec++; if (wr_en !== 1'b1 || wr_addr !== 3'd3 || wr_data !== 64'hDEAD_BEEF) begin
         n_err++; $display("FAIL raw_write: got %b %0d %h expected 1 3 deadbeef", wr_en, wr_addr, wr_data);
      end
      n_vec++; if (stall !== 1'b0) begin
         n_err++; $display("FAIL raw_release: got stall=%b expected 0", stall);
      end
      iss_valid = 0;
      tick();
      @(negedge clk);
      n_vec++; if (busy !== 1'b0 || busy !== (|m_res)) begin
         n_err++; $display("FAIL raw_cleared: got busy=%b expected 0", busy);
      end
      clr_in();
      tick();
   endtask

   task automatic test_round_robin();
      flush = 1;
      tick();
      clr_in();
      fu_valid = 4'b1111;
      fu_addr = {3'd4, 3'd3, 3'd2, 3'd1};
      fu_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_vec++; if (ack !== 4'(1 << (k % 4))) begin
            n_err++; $display("FAIL rr_ack%0d: got %b expected %b", k, ack, 4'(1 << (k % 4)));
         end
         if (k > 0) begin
            n_vec++; if (wr_en !== 1'b1 || wr_addr !== 3'(((k - 1) % 4) + 1)) begin
               n_err++; $display("FAIL rr_wr%0d: got %b %0d expected 1 %0d", k, wr_en, wr_addr,
                                 ((k - 1) % 4) + 1);
            end
         end
         tick();
      end
      fu_valid = 0;
      @(negedge clk);
      n_vec++; if (wr_en !== 1'b1 || wr_addr !== 3'd1 || wr_data !== m_wr_data) begin
         n_err++; $display("FAIL rr_last: got %b %0d expected 1 1", wr_en, wr_addr);
      end
      tick();
   endtask

   task automatic test_const_setclr();
      do_reset();
      iss_valid = 1; iss_dest = 0;
      tick();
      iss_dest = 5; iss_j = 0; iss_k = 0; uses_j = 1; uses_k = 1;
      @(negedge clk);
      n_vec++; if (stall !== 1'b0) begin
         n_err++; $display("FAIL const_operands: got stall=%b expected 0", stall);
      end
      tick();
      clr_in();
      fu_valid = 4'b0001; fu_addr[2:0] = 3'd5; fu_data[63:0] = 64'h5555_0005;
      @(negedge clk);
      n_vec++; if (ack !== 4'b0001) begin
         n_err++; $display("FAIL setclr_ack: got %b expected 0001", ack);
      end
      tick();
      fu_valid = 0; iss_valid = 1; iss_dest = 5;
      @(negedge clk);
      n_vec++; if (wr_en !== 1'b1 || wr_addr !== 3'd5 || stall !== 1'b0) begin
         n_err++; $display("FAIL setclr_issue: got wr_en=%b addr=%0d stall=%b expected 1 5 0",
                           wr_en, wr_addr, stall);
      end
      tick();
      @(negedge clk);
      n_vec++; if (stall !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL setclr_set_wins: got stall=%b busy=%b expected 1 1", stall, busy);
      end
      iss_valid = 0;
      tick();
   endtask

   task automatic test_err_flush();
      do_reset();
      fu_valid = 4'b0100; fu_addr[8:6] = 3'd6; fu_data[191:128] = 64'h6666;
      @(negedge clk);
      n_vec++; if (ack !== 4'b0100 || err !== 1'b0) begin
         n_err++; $display("FAIL err_grant: got ack=%b err=%b expected 0100 0", ack, err);
      end
      tick();
      fu_valid = 0;
      @(negedge clk);
      n_vec++; if (err !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 3'd6) begin
         n_err++; $display("FAIL err_set: got err=%b wr_en=%b addr=%0d expected 1 1 6",
                           err, wr_en, wr_addr);
      end
      for (int d = 4; d < 8; d++) begin
         iss_valid = 1; iss_dest = 3'(d);
         tick();
      end
      iss_valid = 0;
      fu_valid = 4'b0001; fu_addr[2:0] = 3'd4; flush = 1;
      @(negedge clk);
      n_vec++; if (ack !== 4'b0000 || busy !== 1'b1 || err !== 1'b1) begin
         n_err++; $display("FAIL flush_ack: got ack=%b busy=%b err=%b expected 0000 1 1",
                           ack, busy, err);
      end
      tick();
      clr_in();
      @(negedge clk);
      n_vec++; if (busy !== 1'b0 || wr_en !== 1'b0 || err !== 1'b1) begin
         n_err++; $display("FAIL flush_after: got busy=%b wr_en=%b err=%b expected 0 0 1",
                           busy, wr_en, err);
      end
      tick();
   endtask

   task automatic test_random();
      int       g;
      bit [3:0] acked;
      bit [2:0] a;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         g = m_grant();
         n_vec++; if (ack !== ((g >= 0) ? 4'(1 << g) : 4'b0)) begin
            n_err++; $display("FAIL rand_ack c=%0d: got %b expected grant %0d", c, ack, g);
         end
         n_vec++; if (stall !== m_stall()) begin
            n_err++; $display("FAIL rand_stall c=%0d: got %b expected %b", c, stall, m_stall());
         end
         n_vec++; if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
            n_err++; $display("FAIL rand_wr c=%0d: got %b %0d %h expected %b %0d %h", c, wr_en,
                              wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
         end
         n_vec++; if (busy !== (|m_res) || err !== m_err) begin
            n_err++; $display("FAIL rand_status c=%0d: got busy=%b err=%b expected %b %b", c, busy,
                              err, |m_res, m_err);
         end
         acked = (g >= 0) ? 4'(1 << g) : 4'b0;
         tick();
         flush = ($urandom_range(31) == 0);
         iss_valid = $urandom_range(1);
         iss_dest = 3'($urandom); iss_j = 3'($urandom); iss_k = 3'($urandom);
         uses_j = $urandom_range(1); uses_k = $urandom_range(1);
         for (int r = 0; r < 4; r++) begin
            if (!fu_valid[r] || acked[r]) begin
               fu_valid[r] = ($urandom_range(2) == 0);
               a = 3'($urandom);
               // Mostly return results to reserved registers so the error path stays rare.
               for (int t = 0; t < 8 && m_res != 0 && !m_res[a]; t++) a = 3'($urandom);
               fu_addr[r*3 +: 3] = a;
               fu_data[r*64 +: 64] = {$urandom, $urandom};
            end
         end
      end
      clr_in();
   endtask

   initial begin
      test_reset();
      test_raw();
      test_round_robin();
      test_const_setclr();
      test_err_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
